// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer bank.
package timer_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
   localparam int unsigned CLK_HZ_SIM     = 10;

   function automatic int unsigned prescaler_width(input int unsigned hz);
      return $clog2(hz);
   endfunction

   localparam int unsigned PW_DEFAULT = prescaler_width(CLK_HZ_DEFAULT);

endpackage

// File: rtl/timer_channel.sv
// One seconds-resolution countdown channel: prescaler, count, start-time latches and IDLE/RUN FSM.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
   parameter int unsigned VW     = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          pause_i,
   input  logic          periodic_i,
   input  logic [VW-1:0] value_i,
   output logic [VW-1:0] count_o,
   output logic          expired_o,
   output logic          expire_pulse_o
);

   localparam int unsigned    PW        = prescaler_width(CLK_HZ);
   localparam logic [PW-1:0] PrescLast = PW'(CLK_HZ - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [VW-1:0] count_q, count_d;
   logic [VW-1:0] value_q, value_d;
   logic          per_q, per_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      value_d = value_q;
      per_d   = per_q;
      pulse_d = 1'b0;
      if (start_i) begin
         value_d = value_i;
         per_d   = periodic_i;
         presc_d = '0;
         if (value_i != '0) begin
            count_d = value_i;
            state_d = StRun;
         end else begin
            count_d = '0;
            state_d = StIdle;
            pulse_d = 1'b1;
         end
      end else if (state_q == StRun) begin
         if (stop_i) begin
            count_d = '0;
            presc_d = '0;
            state_d = StIdle;
         end else if (!pause_i) begin
            if (presc_q == PrescLast) begin
               // Second boundary: decrement, reload or finish.
               presc_d = '0;
               if (count_q > VW'(1)) begin
                  count_d = count_q - VW'(1);
               end else if (per_q) begin
                  count_d = value_q;
                  pulse_d = 1'b1;
               end else begin
                  count_d = '0;
                  state_d = StIdle;
                  pulse_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         presc_q <= '0;
         count_q <= '0;
         value_q <= '0;
         per_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         value_q <= value_d;
         per_q   <= per_d;
         pulse_q <= pulse_d;
      end
   end

   assign count_o        = count_q;
   assign expired_o      = (count_q == '0);
   assign expire_pulse_o = pulse_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent countdown channels plus free-running 1 Hz / 2 Hz ticks and blink.
module countdown_timer_bank
   import timer_pkg::*;
#(
   parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
   parameter int unsigned CH     = 2,
   parameter int unsigned VW     = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CH-1:0]    start,
   input  logic [CH-1:0]    stop,
   input  logic [CH-1:0]    pause,
   input  logic [CH-1:0]    periodic,
   input  logic [CH*VW-1:0] value,
   output logic [CH*VW-1:0] count,
   output logic [CH-1:0]    expired,
   output logic [CH-1:0]    expire_pulse,
   output logic             tick_1hz,
   output logic             tick_2hz,
   output logic             blink
);

   localparam int unsigned    PW        = prescaler_width(CLK_HZ);
   localparam logic [PW-1:0] PrescLast = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PrescHalf = PW'(CLK_HZ / 2 - 1);

   logic [PW-1:0] gpresc_q, gpresc_d;
   logic          tick1_q, tick1_d;
   logic          tick2_q, tick2_d;
   logic          blink_q, blink_d;

   always_comb begin
      tick1_d  = (gpresc_q == PrescLast);
      tick2_d  = tick1_d || (gpresc_q == PrescHalf);
      gpresc_d = tick1_d ? '0 : gpresc_q + PW'(1);
      blink_d  = blink_q ^ tick2_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gpresc_q <= '0;
         tick1_q  <= 1'b0;
         tick2_q  <= 1'b0;
         blink_q  <= 1'b0;
      end else begin
         gpresc_q <= gpresc_d;
         tick1_q  <= tick1_d;
         tick2_q  <= tick2_d;
         blink_q  <= blink_d;
      end
   end

   assign tick_1hz = tick1_q;
   assign tick_2hz = tick2_q;
   assign blink    = blink_q;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      timer_channel #(
         .CLK_HZ (CLK_HZ),
         .VW     (VW)
      ) u_channel (
         .clock          (clock),
         .reset          (reset),
         .start_i        (start[gi]),
         .stop_i         (stop[gi]),
         .pause_i        (pause[gi]),
         .periodic_i     (periodic[gi]),
         .value_i        (value[gi*VW +: VW]),
         .count_o        (count[gi*VW +: VW]),
         .expired_o      (expired[gi]),
         .expire_pulse_o (expire_pulse[gi])
      );
   end

endmodule
